ray_generator: RTL

//  Upstream sequencer for ray_sphere_intersection. Per pixel: raster-scans the frame, builds ray (p0 = camera, p1 = image-plane point), pulses ENABLE,

---
 rtl/ray_generator.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ray_generator.sv
// Raster-scanning ray sequencer: issues one ray per pixel to the sphere-intersection unit
// and streams each hit/miss result out on a valid/ready interface.
module ray_generator #(
   parameter int unsigned HRes    = 320,
   parameter int unsigned VRes    = 240,
   parameter int unsigned CamX    = 160,
   parameter int unsigned CamY    = 120,
   parameter int unsigned CamZ    = 0,
   parameter int unsigned PlaneZ  = 64,
   parameter int unsigned Timeout = 63
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic [2:0][8:0] ray_p0,
   output logic [2:0][8:0] ray_p1,
   output logic            isect_en,
   input  logic            isect_rdy,
   input  logic            isect_hit,
   output logic            pix_valid,
   input  logic            pix_ready,
   output logic [8:0]      pix_x,
   output logic [8:0]      pix_y,
   output logic            pix_hit,
   output logic            frame_done,
   output logic            timeout_err
);

   localparam int unsigned CntW = $clog2(Timeout + 1);
   localparam logic [8:0] XLast = 9'(HRes - 1);
   localparam logic [8:0] YLast = 9'(VRes - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWaitLo, StWaitHi, StEmit, StDone} state_e;

   state_e          state_q, state_d;
   logic [8:0]      cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [8:0]      pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            busy_q, busy_d, valid_q, valid_d, hit_q, hit_d, terr_q, terr_d;
   logic            timed_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_x_q <= '0;
         cur_y_q <= '0;
         pix_x_q <= '0;
         pix_y_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         hit_q   <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
         pix_x_q <= pix_x_d;
         pix_y_q <= pix_y_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         hit_q   <= hit_d;
         terr_q  <= terr_d;
      end
   end

   assign timed_out = (cnt_q == CntLast);

   always_comb begin
      state_d = state_q;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      hit_d   = hit_q;
      terr_d  = terr_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cur_x_d = '0;
               cur_y_d = '0;
               terr_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWaitLo;
         end
         StWaitLo, StWaitHi: begin
            cnt_d = cnt_q + 1'b1;
            // A high READY in WAIT_LO is the stale level from the previous ray, never a result.
            if (state_q == StWaitLo && !isect_rdy) begin
               state_d = StWaitHi;
            end else if (state_q == StWaitHi && isect_rdy) begin
               hit_d   = isect_hit;
               pix_x_d = cur_x_q;
               pix_y_d = cur_y_q;
               valid_d = 1'b1;
               state_d = StEmit;
            end else if (timed_out) begin
               hit_d   = 1'b0;
               pix_x_d = cur_x_q;
               pix_y_d = cur_y_q;
               valid_d = 1'b1;
               terr_d  = 1'b1;
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (pix_ready) begin
               valid_d = 1'b0;
               state_d = StIssue;
               if (cur_x_q == XLast) begin
                  cur_x_d = '0;
                  if (cur_y_q == YLast) begin
                     cur_y_d = '0;
                     state_d = StDone;
                  end else begin
                     cur_y_d = cur_y_q + 9'd1;
                  end
               end else begin
                  cur_x_d = cur_x_q + 9'd1;
               end
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      isect_en   = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         StIssue: isect_en   = 1'b1;
         StDone:  frame_done = 1'b1;
         default: ;
      endcase
   end

   assign ray_p0[0]   = 9'(CamX);
   assign ray_p0[1]   = 9'(CamY);
   assign ray_p0[2]   = 9'(CamZ);
   assign ray_p1[0]   = cur_x_q;
   assign ray_p1[1]   = cur_y_q;
   assign ray_p1[2]   = 9'(PlaneZ);
   assign busy        = busy_q;
   assign pix_valid   = valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_hit     = hit_q;
   assign timeout_err = terr_q;

endmodule
